// File: rtl/score_bcd_counter.sv
// Score counter: counts food eaten as 3-digit BCD points, flags a win at
// WIN_SCORE and keeps the best score since reset for the display path.
module score_bcd_counter #(
    parameter logic [11:0] WIN_SCORE = 12'h100,
    parameter logic [3:0]  PTS_EASY  = 4'd1,
    parameter logic [3:0]  PTS_MID   = 4'd2,
    parameter logic [3:0]  PTS_HARD  = 4'd5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  game_status,
    input  logic [1:0]  level,
    input  logic        eat_req,
    output logic [11:0] bcd_data,
    output logic [11:0] hi_score,
    output logic        win,
    output logic        eat_ack
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PLAY = 2'b01,
        OVER = 2'b10
    } state_t;

    localparam logic [1:0] GS_START  = 2'b00;
    localparam logic [1:0] GS_SELECT = 2'b01;
    localparam logic [1:0] GS_PLAY   = 2'b10;
    localparam logic [1:0] GS_OVER   = 2'b11;

    state_t      state, state_nxt;
    logic        eat_d;
    logic        eat_rise;
    logic [3:0]  pts, pts_nxt;
    logic [11:0] bcd_nxt, hi_nxt, sum;
    logic        win_nxt, ack_nxt;

    // Points per food for a difficulty setting.
    function automatic logic [3:0] pts_for(input logic [1:0] lvl);
        case (lvl)
            2'b00:   pts_for = PTS_EASY;
            2'b01:   pts_for = PTS_MID;
            default: pts_for = PTS_HARD;
        endcase
    endfunction

    // BCD add of a single-digit value; saturates at 999 instead of wrapping.
    function automatic logic [11:0] bcd_add(input logic [11:0] val, input logic [3:0] add);
        logic [4:0] s0, s1, s2;
        logic       c0, c1;
        s0 = {1'b0, val[3:0]} + {1'b0, add};
        c0 = 1'b0;
        if (s0 > 5'd9) begin
            s0 = s0 - 5'd10;
            c0 = 1'b1;
        end
        s1 = {1'b0, val[7:4]} + {4'd0, c0};
        c1 = 1'b0;
        if (s1 > 5'd9) begin
            s1 = 5'd0;
            c1 = 1'b1;
        end
        s2 = {1'b0, val[11:8]} + {4'd0, c1};
        if (s2 > 5'd9)
            bcd_add = 12'h999;
        else
            bcd_add = {s2[3:0], s1[3:0], s0[3:0]};
    endfunction

    assign eat_rise = eat_req & ~eat_d;
    assign sum      = bcd_add(bcd_data, pts);

    // Next-state and next-output decode; a status change always wins over a food in the same cycle.
    always_comb begin
        state_nxt = state;
        pts_nxt   = pts;
        bcd_nxt   = bcd_data;
        hi_nxt    = hi_score;
        win_nxt   = win;
        ack_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (game_status == GS_START) begin
                    bcd_nxt = 12'h000;
                    win_nxt = 1'b0;
                end else if (game_status == GS_PLAY) begin
                    state_nxt = PLAY;
                    pts_nxt   = pts_for(level);
                end
            end
            PLAY: begin
                case (game_status)
                    GS_PLAY: begin
                        if (eat_rise) begin
                            bcd_nxt = sum;
                            ack_nxt = 1'b1;
                            if (sum >= WIN_SCORE)
                                win_nxt = 1'b1;
                        end
                    end
                    GS_OVER: state_nxt = OVER;
                    GS_START: begin
                        state_nxt = IDLE;
                        bcd_nxt   = 12'h000;
                        win_nxt   = 1'b0;
                    end
                    GS_SELECT: state_nxt = IDLE;
                    default:   state_nxt = IDLE;
                endcase
            end
            OVER: begin
                // Score is frozen here, so refreshing every cycle equals refreshing on entry.
                if (bcd_data > hi_score)
                    hi_nxt = bcd_data;
                if (game_status == GS_START) begin
                    state_nxt = IDLE;
                    bcd_nxt   = 12'h000;
                    win_nxt   = 1'b0;
                end else if (game_status == GS_PLAY) begin
                    state_nxt = PLAY;
                    pts_nxt   = pts_for(level);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            eat_d    <= 1'b0;
            pts      <= PTS_EASY;
            bcd_data <= 12'h000;
            hi_score <= 12'h000;
            win      <= 1'b0;
            eat_ack  <= 1'b0;
        end else begin
            state    <= state_nxt;
            eat_d    <= eat_req;
            pts      <= pts_nxt;
            bcd_data <= bcd_nxt;
            hi_score <= hi_nxt;
            win      <= win_nxt;
            eat_ack  <= ack_nxt;
        end
    end

endmodule

// File: tb/tb_score_bcd_counter.sv
// Bench for score_bcd_counter: directed scenarios plus random stimulus, all
// checked every cycle against an integer-score reference model.
module tb_score_bcd_counter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  game_status;
    logic [1:0]  level;
    logic        eat_req;
    logic [11:0] bcd_data;
    logic [11:0] hi_score;
    logic        win;
    logic        eat_ack;

    int total = 0;
    int bad   = 0;

    // Reference model: score kept as a plain integer, phase as a small number.
    int m_score, m_hi, m_pts, m_phase;   // phase 0 lobby, 1 playing, 2 game over
    bit m_win, m_ack, m_prev_eat;
    int ack_cnt;

    score_bcd_counter dut (
        .clk         (clk),
        .rst         (rst),
        .game_status (game_status),
        .level       (level),
        .eat_req     (eat_req),
        .bcd_data    (bcd_data),
        .hi_score    (hi_score),
        .win         (win),
        .eat_ack     (eat_ack)
    );

    always #20 clk = ~clk;

    function automatic logic [11:0] to_bcd(input int v);
        logic [3:0] h, t, o;
        h = 4'(v / 100);
        t = 4'((v / 10) % 10);
        o = 4'(v % 10);
        return {h, t, o};
    endfunction

    function automatic int pts_of(input logic [1:0] lvl);
        return (lvl == 2'b00) ? 1 : (lvl == 2'b01) ? 2 : 5;
    endfunction

    task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_update();
        bit rise;
        if (rst) begin
            m_score = 0; m_hi = 0; m_win = 0; m_ack = 0;
            m_prev_eat = 0; m_pts = 1; m_phase = 0;
            return;
        end
        rise       = eat_req && !m_prev_eat;
        m_prev_eat = eat_req;
        m_ack      = 0;
        if (m_phase == 0) begin
            if (game_status == 2'b00) begin
                m_score = 0; m_win = 0;
            end else if (game_status == 2'b10) begin
                m_phase = 1; m_pts = pts_of(level);
            end
        end else if (m_phase == 1) begin
            if (game_status == 2'b10) begin
                if (rise) begin
                    m_score = (m_score + m_pts > 999) ? 999 : m_score + m_pts;
                    m_ack   = 1;
                    if (m_score >= 100) m_win = 1;
                end
            end else if (game_status == 2'b11) begin
                m_phase = 2;
            end else if (game_status == 2'b00) begin
                m_phase = 0; m_score = 0; m_win = 0;
            end else begin
                m_phase = 0;
            end
        end else begin
            if (m_score > m_hi) m_hi = m_score;
            if (game_status == 2'b00) begin
                m_phase = 0; m_score = 0; m_win = 0;
            end else if (game_status == 2'b10) begin
                m_phase = 1; m_pts = pts_of(level);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        chk("bcd_data", bcd_data, to_bcd(m_score));
        chk("hi_score", hi_score, to_bcd(m_hi));
        chk("win", {11'd0, win}, {11'd0, m_win});
        chk("eat_ack", {11'd0, eat_ack}, {11'd0, m_ack});
        if (eat_ack === 1'b1) ack_cnt++;
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            eat_req = 1'b1; step();
            eat_req = 1'b0; step();
        end
    endtask

    initial begin
        int acks0;
        rst = 1'b1; game_status = 2'b00; level = 2'b00; eat_req = 1'b0; ack_cnt = 0;
        m_score = 0; m_hi = 0; m_pts = 1; m_phase = 0; m_win = 0; m_ack = 0; m_prev_eat = 0;

        // Reset with eat_req toggling
        eat_req = 1'b1; step();
        eat_req = 1'b0; step();
        chk("rst_bcd", bcd_data, 12'h000);
        chk("rst_ack", {11'd0, eat_ack}, 12'h000);
        rst = 1'b0; step();

        // Easy level, three foods
        level = 2'b00; game_status = 2'b10; step();
        ack_cnt = 0;
        pulses(3);
        chk("easy_bcd", bcd_data, 12'h003);
        chk("easy_acks", 12'(ack_cnt), 12'd3);
        game_status = 2'b00; step();

        // Hard level up to the win threshold, then held eat_req
        level = 2'b10; game_status = 2'b10; step();
        pulses(2);
        chk("hard_010", bcd_data, 12'h010);
        pulses(18);
        chk("hard_100", bcd_data, 12'h100);
        chk("win_set", {11'd0, win}, 12'd1);
        eat_req = 1'b1;
        repeat (10) step();
        eat_req = 1'b0; step();
        chk("held_once", bcd_data, 12'h105);
        game_status = 2'b00; step();
        chk("win_clr", {11'd0, win}, 12'd0);

        // Saturation at 999
        level = 2'b10; game_status = 2'b10; step();
        pulses(199);
        chk("sat_995", bcd_data, 12'h995);
        pulses(1);
        chk("sat_999", bcd_data, 12'h999);
        acks0 = ack_cnt;
        pulses(1);
        chk("sat_hold", bcd_data, 12'h999);
        chk("sat_ack", 12'(ack_cnt - acks0), 12'd1);
        game_status = 2'b00; step();

        // High score: a 030 game, then a 042 game
        level = 2'b10; game_status = 2'b10; step();
        pulses(6);
        game_status = 2'b11; step(); step();
        chk("hi_030", hi_score, 12'h030);
        game_status = 2'b00; step();
        level = 2'b01; game_status = 2'b10; step();
        pulses(21);
        chk("score_042", bcd_data, 12'h042);
        game_status = 2'b11; step(); step();
        chk("hi_042", hi_score, 12'h042);
        acks0 = ack_cnt;
        pulses(1);
        chk("over_frozen", bcd_data, 12'h042);
        chk("over_noack", 12'(ack_cnt - acks0), 12'd0);
        game_status = 2'b00; step();
        chk("over_clr", bcd_data, 12'h000);
        chk("hi_kept", hi_score, 12'h042);

        // Food coincident with leaving play is dropped
        game_status = 2'b10; step();
        pulses(3);
        acks0 = ack_cnt;
        eat_req = 1'b1; game_status = 2'b11; step();
        eat_req = 1'b0; step();
        chk("drop_bcd", bcd_data, 12'h006);
        chk("drop_ack", 12'(ack_cnt - acks0), 12'd0);
        game_status = 2'b00; step();

        // Reset in the middle of a game
        level = 2'b00; game_status = 2'b10; step();
        pulses(37);
        chk("pre_rst", bcd_data, 12'h037);
        rst = 1'b1; step();
        chk("mid_rst_bcd", bcd_data, 12'h000);
        chk("mid_rst_hi", hi_score, 12'h000);
        rst = 1'b0;

        // Random play
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 24) == 0) game_status = 2'($urandom);
            else if ($urandom_range(0, 9) == 0) game_status = 2'b10;
            if ($urandom_range(0, 9) == 0) level = 2'($urandom);
            eat_req = ($urandom_range(0, 2) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
